t_mux_2to1: RTL and testbench



---
 rtl/t_mux_pkg.sv | 17 +
 rtl/t_mux_sel_sync.sv | 37 +++
 rtl/t_mux_2to1.sv | 55 +++++
 tb/tb_t_mux_2to1.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/t_mux_pkg.sv
// Shared definitions for the t_mux_2to1 steering cell: width limit, select encoding
// and synchroniser depth used when T_MUX_SEL_SYNC_EN is defined.
package t_mux_pkg;

  localparam int T_MUX_WIDTH_MAX   = 64;
  localparam int T_MUX_SYNC_STAGES = 2;

  typedef enum logic {
    SEL_I0 = 1'b0,
    SEL_I1 = 1'b1
  } sel_e;

  function automatic bit width_is_legal(input int width);
    return (width >= 1) && (width <= T_MUX_WIDTH_MAX);
  endfunction

endpackage

// File: rtl/t_mux_sel_sync.sv
// Multi-flop synchroniser for the mux select; every stage resets to SEL_I0 so the
// mux picks i0 until a real select value has propagated through the chain.
module t_mux_sel_sync
  import t_mux_pkg::*;
#(
  parameter int STAGES = T_MUX_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic sel_async,
  output logic sel_sync
);

  logic [STAGES:0] chain;

  assign chain[0] = sel_async;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic stage_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          stage_reg <= SEL_I0;
        end else begin
          stage_reg <= chain[gi];
        end
      end

      assign chain[gi+1] = stage_reg;
    end
  endgenerate

  assign sel_sync = chain[STAGES];

endmodule

// File: rtl/t_mux_2to1.sv
// Parameterised 2:1 mux with a combinational output y and a registered copy y_q.
// Optional macro T_MUX_SEL_SYNC_EN routes sel through a 2-flop synchroniser first.
module t_mux_2to1
  import t_mux_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sel,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q
);

  logic             sel_eff;
  logic [WIDTH-1:0] y_next;
  logic [WIDTH-1:0] y_q_reg;

`ifdef T_MUX_SEL_SYNC_EN
  t_mux_sel_sync #(
    .STAGES(T_MUX_SYNC_STAGES)
  ) u_sel_sync (
    .clk      (clk),
    .reset    (reset),
    .sel_async(sel),
    .sel_sync (sel_eff)
  );
`else
  assign sel_eff = sel;
`endif

  // An unknown select propagates as X instead of silently favouring one input.
  always_comb begin
    case (sel_e'(sel_eff))
      SEL_I0:  y_next = i0;
      SEL_I1:  y_next = i1;
      default: y_next = 'x;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_q_reg <= RST_VAL;
    end else begin
      y_q_reg <= y_next;
    end
  end

  assign y   = y_next;
  assign y_q = y_q_reg;

endmodule

// File: tb/tb_t_mux_2to1.sv
// Self-checking bench for t_mux_2to1: directed cases plus randomized traffic on a
// 1-bit and an 8-bit instance, compared against a behavioural select/data model.
module tb_t_mux_2to1;

  localparam logic [7:0] RST8 = 8'h5A;
`ifdef T_MUX_SEL_SYNC_EN
  localparam int LAT_Y = 2;
  localparam int LAT_Q = 3;
`else
  localparam int LAT_Y = 0;
  localparam int LAT_Q = 1;
`endif

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       sel   = 1'b0;
  logic       i0_1  = 1'b0;
  logic       i1_1  = 1'b0;
  logic       y1;
  logic       yq1;
  logic [7:0] i0_8  = 8'h00;
  logic [7:0] i1_8  = 8'h00;
  logic [7:0] y8;
  logic [7:0] yq8;

  int checks = 0;
  int errors = 0;

  t_mux_2to1 #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .sel(sel), .i0(i0_1), .i1(i1_1), .y(y1), .y_q(yq1)
  );

  t_mux_2to1 #(.WIDTH(8), .RST_VAL(RST8)) dut8 (
    .clk(clk), .reset(reset), .sel(sel), .i0(i0_8), .i1(i1_8), .y(y8), .y_q(yq8)
  );

  always #5 clk = ~clk;

  // Reference model: the select the mux acts on is either the live sel, or the
  // sel value seen two rising edges ago (0 until two edges have passed since reset).
  bit         sel_hist[$];
  logic       exp_q1;
  logic [7:0] exp_q8;

  function automatic logic model_sel();
`ifdef T_MUX_SEL_SYNC_EN
    return (sel_hist.size() >= 2) ? sel_hist[sel_hist.size()-2] : 1'b0;
`else
    return sel;
`endif
  endfunction

  function automatic logic exp_y1();
    return model_sel() ? i1_1 : i0_1;
  endfunction

  function automatic logic [7:0] exp_y8();
    return model_sel() ? i1_8 : i0_8;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q1 <= 1'b0;
      exp_q8 <= RST8;
      sel_hist.delete();
    end else begin
      exp_q1 <= exp_y1();
      exp_q8 <= exp_y8();
      sel_hist.push_back(sel);
      if (sel_hist.size() > 2) void'(sel_hist.pop_front());
    end
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    check_val({tag, "_y1"},  y1,  exp_y1());
    check_val({tag, "_y8"},  y8,  exp_y8());
    check_val({tag, "_yq1"}, yq1, exp_q1);
    check_val({tag, "_yq8"}, yq8, exp_q8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int t;

    // Reset state without any clock edge
    #1 reset = 1'b1;
    #1;
    check_val("rst_yq1", yq1, 1'b0);
    check_val("rst_yq8", yq8, RST8);
    check_val("rst_y8", y8, 8'h00);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Static select, WIDTH=1
    next_edge();
    sel = 1'b0; i0_1 = 1'b1; i1_1 = 1'b0;
    repeat (3) next_edge();
    check_val("static_y_sel0", y1, 1'b1);
    sel = 1'b1;
    #1;
    check_all("static_sel1");
`ifndef T_MUX_SEL_SYNC_EN
    check_val("static_y_sel1_const", y1, 1'b0);
`endif
    next_edge();
    check_all("static_edge");
`ifndef T_MUX_SEL_SYNC_EN
    check_val("static_yq_const", yq1, 1'b0);
`endif

    // Wide data, WIDTH=8
    sel = 1'b0; i0_8 = 8'hA5; i1_8 = 8'h3C;
    repeat (3) next_edge();
    check_val("wide_y_sel0", y8, 8'hA5);
    sel = 1'b1;
    #1;
    check_all("wide_sel1");
    repeat (LAT_Q) next_edge();
    check_val("wide_yq_3c", yq8, 8'h3C);
    check_val("wide_y_3c", y8, 8'h3C);

    // Free-running toggles: i0 period 20, i1 period 110, sel period 150
    next_edge();
    for (t = 0; t <= 300; t += 5) begin
      i0_1 = ((t / 10) % 2) != 0;
      i1_1 = ((t / 55) % 2) != 0;
      sel  = ((t / 75) % 2) != 0;
      #1;
      check_val($sformatf("toggle_t%0d", t), y1, exp_y1());
`ifndef T_MUX_SEL_SYNC_EN
      if (t == 15)  check_val("toggle_t15_const",  y1, 1'b1);
      if (t == 80)  check_val("toggle_t80_const",  y1, 1'b1);
      if (t == 115) check_val("toggle_t115_const", y1, 1'b0);
      if (t == 155) check_val("toggle_t155_const", y1, 1'b1);
`endif
      #4;
    end

    // Asynchronous reset mid-cycle with y_q=1
    sel = 1'b0; i0_1 = 1'b1; i1_1 = 1'b0;
    repeat (4) next_edge();
    check_val("pre_rst_yq1", yq1, 1'b1);
    #3 reset = 1'b1;
    #1;
    check_val("mid_rst_yq1", yq1, 1'b0);
    check_val("mid_rst_yq8", yq8, RST8);
    check_val("mid_rst_y1", y1, exp_y1());
    check_val("mid_rst_y1_i0", y1, 1'b1);
    #2 reset = 1'b0;
    next_edge();
    check_val("rel_yq1_eq_y", yq1, exp_y1());
    check_all("rel");

    // Select latency to y and y_q
    sel = 1'b0; i0_1 = 1'b0; i1_1 = 1'b1;
    repeat (4) next_edge();
    sel = 1'b1;
    cnt = 0;
    #1;
    while (y1 !== 1'b1 && cnt < 8) begin next_edge(); cnt++; end
    check_val("lat_y", cnt, LAT_Y);
    sel = 1'b0;
    repeat (4) next_edge();
    sel = 1'b1;
    cnt = 0;
    #1;
    while (yq1 !== 1'b1 && cnt < 8) begin next_edge(); cnt++; end
    check_val("lat_yq", cnt, LAT_Q);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 200; n++) begin
      next_edge();
      sel  = 1'($urandom);
      i0_1 = 1'($urandom);
      i1_1 = 1'($urandom);
      i0_8 = 8'($urandom);
      i1_8 = 8'($urandom);
      reset = ($urandom_range(0, 39) == 0);
      #1;
      check_all($sformatf("rnd%0d_a", n));
      @(negedge clk);
      check_all($sformatf("rnd%0d_b", n));
      $display("txn %0d rst=%0b sel=%0b i0=%02h i1=%02h y=%02h y_q=%02h",
               n, reset, sel, i0_8, i1_8, y8, yq8);
      reset = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
